// File: rtl/wasm_pkg.sv
// Shared definitions for the wasm loader blocks: LEB128 decode constants,
// the reader FSM state encoding and a payload-placement helper.
package wasm_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        DONE  = 2'd2
    } leb_state_e;

    localparam int         LEB_U32_MAX_BYTES = 5;
    localparam logic [7:0] LEB_PAYLOAD_MASK  = 8'h7F;
    localparam int         LEB_CONT_BIT      = 7;

    // Places the 7-bit payload of one encoded byte at its bit offset in the result.
    function automatic logic [31:0] leb_payload_at(input logic [7:0] b, input logic [7:0] shamt);
        return {24'd0, b & LEB_PAYLOAD_MASK} << shamt;
    endfunction

endpackage

// File: rtl/leb128_reader_if.sv
// ROM byte-read handshake between the LEB128 reader (master) and the ROM responder (slave).
interface leb128_reader_if;
    logic [31:0] rom_addr;
    logic        rom_read_en;
    logic [7:0]  rom_data;
    logic        rom_ready;

    modport master (output rom_addr, output rom_read_en, input rom_data, input rom_ready);
    modport slave  (input rom_addr, input rom_read_en, output rom_data, output rom_ready);
endinterface

// File: rtl/leb128_reader.sv
// LEB128 (u32/s32) decoder that fetches one byte per request over the ROM
// handshake and reports the decoded value plus the address after the encoding.
module leb128_reader
    import wasm_pkg::*;
#(
    parameter bit SIGNED    = 1'b0,
    parameter int MAX_BYTES = LEB_U32_MAX_BYTES,
    parameter int TIMEOUT   = 16
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   start,
    input  logic [31:0]            start_addr,
    output logic                   busy,
    output logic                   done,
    output logic                   error,
    output logic [31:0]            value,
    output logic [31:0]            next_addr,
    leb128_reader_if.master        rom
);

    localparam int CNT_W = $clog2(TIMEOUT + 1);
    localparam int IDX_W = $clog2(MAX_BYTES + 1);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(MAX_BYTES - 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    leb_state_e       r_state,    w_state_nxt;
    logic [31:0]      r_acc,      w_acc_nxt;
    logic [IDX_W-1:0] r_idx,      w_idx_nxt;
    logic [CNT_W-1:0] r_cnt,      w_cnt_nxt;
    logic             r_busy,     w_busy_nxt;
    logic             r_done,     w_done_nxt;
    logic             r_error,    w_error_nxt;
    logic [31:0]      r_value,    w_value_nxt;
    logic [31:0]      r_next,     w_next_nxt;
    logic [31:0]      r_rom_addr, w_rom_addr_nxt;
    logic             r_rd_en,    w_rd_en_nxt;

    logic [7:0]  w_shamt;
    logic [7:0]  w_ext_shamt;
    logic [31:0] w_acc_upd;
    logic [31:0] w_result;
    logic        w_last;
    logic        w_more;
    logic        w_ovf;

    // Byte accumulation, final-byte range check and sign extension.
    always_comb begin
        w_shamt     = 8'(32'd7 * 32'(r_idx));
        w_ext_shamt = 8'(32'd7 * (32'(r_idx) + 32'd1));
        w_acc_upd   = r_acc | leb_payload_at(rom.rom_data, w_shamt);
        w_last      = (r_idx == LAST_IDX);
        w_more      = rom.rom_data[LEB_CONT_BIT] && !w_last;
        w_ovf       = 1'b0;
        w_result    = w_acc_upd;
        if (w_last) begin
            if (SIGNED) begin
                w_ovf = rom.rom_data[LEB_CONT_BIT] || (rom.rom_data[6:4] != {3{rom.rom_data[3]}});
            end else begin
                w_ovf = rom.rom_data[LEB_CONT_BIT] || (rom.rom_data[6:4] != 3'd0);
            end
        end else begin
            w_ovf = 1'b0;
        end
        if (SIGNED && rom.rom_data[6] && (w_ext_shamt < 8'd32)) begin
            w_result = w_acc_upd | (32'hFFFF_FFFF << w_ext_shamt);
        end else begin
            w_result = w_acc_upd;
        end
    end

    // Next-state and next-output logic; every output is taken from a register.
    always_comb begin
        w_state_nxt    = r_state;
        w_acc_nxt      = r_acc;
        w_idx_nxt      = r_idx;
        w_cnt_nxt      = r_cnt;
        w_busy_nxt     = r_busy;
        w_done_nxt     = 1'b0;
        w_error_nxt    = r_error;
        w_value_nxt    = r_value;
        w_next_nxt     = r_next;
        w_rom_addr_nxt = r_rom_addr;
        w_rd_en_nxt    = r_rd_en;
        case (r_state)
            IDLE: begin
                if (start) begin
                    w_state_nxt    = FETCH;
                    w_rom_addr_nxt = start_addr;
                    w_acc_nxt      = 32'd0;
                    w_idx_nxt      = '0;
                    w_cnt_nxt      = '0;
                    w_busy_nxt     = 1'b1;
                    w_rd_en_nxt    = 1'b1;
                end else begin
                    w_state_nxt = IDLE;
                end
            end
            FETCH: begin
                // A response in the final timeout cycle still counts.
                if (rom.rom_ready) begin
                    w_acc_nxt = w_acc_upd;
                    if (w_more) begin
                        w_rom_addr_nxt = r_rom_addr + 32'd1;
                        w_idx_nxt      = r_idx + IDX_W'(1);
                        w_cnt_nxt      = '0;
                    end else begin
                        w_state_nxt = DONE;
                        w_busy_nxt  = 1'b0;
                        w_rd_en_nxt = 1'b0;
                        w_done_nxt  = 1'b1;
                        w_error_nxt = w_ovf;
                        w_value_nxt = w_ovf ? 32'd0 : w_result;
                        w_next_nxt  = r_rom_addr + 32'd1;
                    end
                end else if (r_cnt == CNT_LAST) begin
                    w_state_nxt = DONE;
                    w_busy_nxt  = 1'b0;
                    w_rd_en_nxt = 1'b0;
                    w_done_nxt  = 1'b1;
                    w_error_nxt = 1'b1;
                    w_value_nxt = 32'd0;
                    w_next_nxt  = r_rom_addr;
                end else begin
                    w_cnt_nxt = r_cnt + CNT_W'(1);
                end
            end
            DONE: begin
                w_state_nxt = IDLE;
            end
            default: begin
                w_state_nxt = IDLE;
                w_busy_nxt  = 1'b0;
                w_rd_en_nxt = 1'b0;
            end
        endcase
    end

    // State and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= IDLE;
            r_acc      <= 32'd0;
            r_idx      <= '0;
            r_cnt      <= '0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_error    <= 1'b0;
            r_value    <= 32'd0;
            r_next     <= 32'd0;
            r_rom_addr <= 32'd0;
            r_rd_en    <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_acc      <= w_acc_nxt;
            r_idx      <= w_idx_nxt;
            r_cnt      <= w_cnt_nxt;
            r_busy     <= w_busy_nxt;
            r_done     <= w_done_nxt;
            r_error    <= w_error_nxt;
            r_value    <= w_value_nxt;
            r_next     <= w_next_nxt;
            r_rom_addr <= w_rom_addr_nxt;
            r_rd_en    <= w_rd_en_nxt;
        end
    end

    assign busy            = r_busy;
    assign done            = r_done;
    assign error           = r_error;
    assign value           = r_value;
    assign next_addr       = r_next;
    assign rom.rom_addr    = r_rom_addr;
    assign rom.rom_read_en = r_rd_en;

endmodule

// File: tb/tb_leb128_reader.sv
// Self-checking bench for leb128_reader: unsigned and signed instances, each
// with a registered ROM responder that ignores repeats of its last address.
module tb_leb128_reader;

    typedef struct packed {
        logic [31:0] value;
        logic [31:0] next_addr;
        logic        error;
        logic [7:0]  cyc;
    } res_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic        start_u, start_s;
    logic [31:0] saddr_u, saddr_s;
    logic        busy_u, done_u, err_u, busy_s, done_s, err_s;
    logic [31:0] val_u, na_u, val_s, na_s;

    leb128_reader_if rom_u ();
    leb128_reader_if rom_s ();

    leb128_reader #(.SIGNED(1'b0), .MAX_BYTES(5), .TIMEOUT(16)) u_dut (
        .clk(clk), .rst_n(rst_n), .start(start_u), .start_addr(saddr_u),
        .busy(busy_u), .done(done_u), .error(err_u), .value(val_u), .next_addr(na_u),
        .rom(rom_u)
    );

    leb128_reader #(.SIGNED(1'b1), .MAX_BYTES(5), .TIMEOUT(16)) u_dut_s (
        .clk(clk), .rst_n(rst_n), .start(start_s), .start_addr(saddr_s),
        .busy(busy_s), .done(done_s), .error(err_s), .value(val_s), .next_addr(na_s),
        .rom(rom_s)
    );

    logic [7:0]  mem_u [256];
    logic [7:0]  mem_s [256];
    logic [31:0] last_u, last_s;
    int          wait_u, wait_s;
    int          delay_u, delay_s;

    int n_checks = 0;
    int n_fail   = 0;

    res_t        sb_q [$];
    res_t        obs, exp_r;
    logic        obs_rd_done, obs_busy_ok;
    logic [31:0] addr_log [$];

    // Responder for the unsigned reader: optional extra wait, ignores its last address.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rom_u.rom_ready <= 1'b0; rom_u.rom_data <= 8'd0; last_u <= 32'd0; wait_u <= 0;
        end else begin
            rom_u.rom_ready <= 1'b0;
            if (rom_u.rom_read_en && rom_u.rom_addr != last_u) begin
                if (wait_u >= delay_u) begin
                    rom_u.rom_data  <= mem_u[rom_u.rom_addr[7:0]];
                    rom_u.rom_ready <= 1'b1;
                    last_u <= rom_u.rom_addr;
                    wait_u <= 0;
                end else begin
                    wait_u <= wait_u + 1;
                end
            end else begin
                wait_u <= 0;
            end
        end
    end

    // Responder for the signed reader.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rom_s.rom_ready <= 1'b0; rom_s.rom_data <= 8'd0; last_s <= 32'd0; wait_s <= 0;
        end else begin
            rom_s.rom_ready <= 1'b0;
            if (rom_s.rom_read_en && rom_s.rom_addr != last_s) begin
                if (wait_s >= delay_s) begin
                    rom_s.rom_data  <= mem_s[rom_s.rom_addr[7:0]];
                    rom_s.rom_ready <= 1'b1;
                    last_s <= rom_s.rom_addr;
                    wait_s <= 0;
                end else begin
                    wait_s <= wait_s + 1;
                end
            end else begin
                wait_s <= 0;
            end
        end
    end

    function automatic string fmt_res(res_t r);
        return $sformatf("val=%h next=%h err=%0b cyc=%0d", r.value, r.next_addr, r.error, r.cyc);
    endfunction

    // Starts one decode (earliest legal cycle) and records what the DUT reports.
    task automatic run_decode(input bit sgn, input logic [31:0] addr, input int inject_at);
        bit seen;
        logic d, b, rd;
        logic [31:0] ra;
        seen = 1'b0;
        obs = '0;
        obs_busy_ok = 1'b1;
        obs_rd_done = 1'b1;
        addr_log.delete();
        @(posedge clk); #1;
        if (sgn) begin start_s = 1'b1; saddr_s = addr; end
        else     begin start_u = 1'b1; saddr_u = addr; end
        @(posedge clk); #1;
        start_u = 1'b0; start_s = 1'b0;
        for (int c = 1; c <= 60 && !seen; c++) begin
            @(negedge clk);
            if (c == inject_at) begin
                if (sgn) begin start_s = 1'b1; saddr_s = 32'h10; end
                else     begin start_u = 1'b1; saddr_u = 32'h10; end
            end else begin
                start_u = 1'b0; start_s = 1'b0;
            end
            d  = sgn ? done_s : done_u;
            b  = sgn ? busy_s : busy_u;
            rd = sgn ? rom_s.rom_read_en : rom_u.rom_read_en;
            ra = sgn ? rom_s.rom_addr : rom_u.rom_addr;
            if (d) begin
                seen = 1'b1;
                obs.value     = sgn ? val_s : val_u;
                obs.next_addr = sgn ? na_s : na_u;
                obs.error     = sgn ? err_s : err_u;
                obs.cyc       = 8'(c);
                obs_rd_done   = rd;
                if (b) obs_busy_ok = 1'b0;
            end else begin
                if (!b) obs_busy_ok = 1'b0;
                if (rd && (addr_log.size() == 0 || addr_log[$] != ra)) addr_log.push_back(ra);
            end
        end
        if (!seen) begin
            n_checks++; n_fail++;
            $display("FAIL decode_bound addr=%h: no done within 60 cycles", addr);
        end
    endtask

    task automatic test_reset();
        @(negedge clk);
        n_checks++;
        if ({busy_u, done_u, err_u, val_u, na_u, rom_u.rom_addr, rom_u.rom_read_en} !== 99'd0) begin
            n_fail++;
            $display("FAIL reset_u got busy=%b done=%b err=%b val=%h next=%h addr=%h rd=%b want all 0",
                     busy_u, done_u, err_u, val_u, na_u, rom_u.rom_addr, rom_u.rom_read_en);
        end
        n_checks++;
        if ({busy_s, done_s, err_s, val_s, na_s, rom_s.rom_addr, rom_s.rom_read_en} !== 99'd0) begin
            n_fail++;
            $display("FAIL reset_s got busy=%b done=%b err=%b val=%h next=%h addr=%h rd=%b want all 0",
                     busy_s, done_s, err_s, val_s, na_s, rom_s.rom_addr, rom_s.rom_read_en);
        end
        rst_n = 1'b1;
        @(negedge clk);
        n_checks++;
        if ({busy_u, done_u, rom_u.rom_read_en} !== 3'b000) begin
            n_fail++;
            $display("FAIL idle_after_reset got busy=%b done=%b rd=%b want 000", busy_u, done_u, rom_u.rom_read_en);
        end
    endtask

    task automatic test_timeout();
        sb_q.push_back('{value: 32'h0, next_addr: 32'h0, error: 1'b1, cyc: 8'd17});
        run_decode(1'b0, 32'h0, 0);
        exp_r = sb_q.pop_front();
        n_checks++;
        if (obs !== exp_r) begin
            n_fail++; $display("FAIL timeout got %s want %s", fmt_res(obs), fmt_res(exp_r));
        end
    endtask

    task automatic test_single_byte();
        mem_u[8'h10] = 8'h05;
        sb_q.push_back('{value: 32'h5, next_addr: 32'h11, error: 1'b0, cyc: 8'd3});
        run_decode(1'b0, 32'h10, 0);
        exp_r = sb_q.pop_front();
        n_checks++;
        if (obs !== exp_r) begin
            n_fail++; $display("FAIL single_byte got %s want %s", fmt_res(obs), fmt_res(exp_r));
        end
        n_checks++;
        if ({obs_rd_done, obs_busy_ok} !== 2'b01) begin
            n_fail++; $display("FAIL single_flags got rd_at_done=%b busy_ok=%b want 0 1", obs_rd_done, obs_busy_ok);
        end
    endtask

    task automatic test_multi_byte();
        mem_u[8'h20] = 8'hE5; mem_u[8'h21] = 8'h8E; mem_u[8'h22] = 8'h26;
        sb_q.push_back('{value: 32'h0009_8765, next_addr: 32'h23, error: 1'b0, cyc: 8'd7});
        run_decode(1'b0, 32'h20, 0);
        exp_r = sb_q.pop_front();
        n_checks++;
        if (obs !== exp_r) begin
            n_fail++; $display("FAIL multi_byte got %s want %s", fmt_res(obs), fmt_res(exp_r));
        end
        n_checks++;
        if (addr_log.size() != 3 || addr_log[0] !== 32'h20 || addr_log[1] !== 32'h21 || addr_log[2] !== 32'h22) begin
            n_fail++; $display("FAIL multi_addr_seq got %p want 20 21 22", addr_log);
        end
        n_checks++;
        if (obs_busy_ok !== 1'b1) begin
            n_fail++; $display("FAIL multi_busy got gap=%b want busy through 1..6 and low at done", ~obs_busy_ok);
        end
    endtask

    task automatic test_max_len();
        for (int i = 0; i < 4; i++) mem_u[8'h30 + 8'(i)] = 8'hFF;
        mem_u[8'h34] = 8'h0F;
        sb_q.push_back('{value: 32'hFFFF_FFFF, next_addr: 32'h35, error: 1'b0, cyc: 8'd11});
        run_decode(1'b0, 32'h30, 0);
        exp_r = sb_q.pop_front();
        n_checks++;
        if (obs !== exp_r) begin
            n_fail++; $display("FAIL max_len_ok got %s want %s", fmt_res(obs), fmt_res(exp_r));
        end
        mem_u[8'h34] = 8'h1F;
        sb_q.push_back('{value: 32'h0, next_addr: 32'h35, error: 1'b1, cyc: 8'd11});
        run_decode(1'b0, 32'h30, 0);
        exp_r = sb_q.pop_front();
        n_checks++;
        if (obs !== exp_r) begin
            n_fail++; $display("FAIL overflow_bits got %s want %s", fmt_res(obs), fmt_res(exp_r));
        end
        for (int i = 0; i < 4; i++) mem_u[8'h50 + 8'(i)] = 8'h81;
        mem_u[8'h54] = 8'h80;
        sb_q.push_back('{value: 32'h0, next_addr: 32'h55, error: 1'b1, cyc: 8'd11});
        run_decode(1'b0, 32'h50, 0);
        exp_r = sb_q.pop_front();
        n_checks++;
        if (obs !== exp_r) begin
            n_fail++; $display("FAIL overflow_cont got %s want %s", fmt_res(obs), fmt_res(exp_r));
        end
    endtask

    task automatic test_ready_boundary();
        mem_u[8'h60] = 8'h07;
        delay_u = 14;
        sb_q.push_back('{value: 32'h7, next_addr: 32'h61, error: 1'b0, cyc: 8'd17});
        run_decode(1'b0, 32'h60, 0);
        exp_r = sb_q.pop_front();
        n_checks++;
        if (obs !== exp_r) begin
            n_fail++; $display("FAIL ready_wins got %s want %s", fmt_res(obs), fmt_res(exp_r));
        end
        mem_u[8'h61] = 8'h09;
        delay_u = 15;
        sb_q.push_back('{value: 32'h0, next_addr: 32'h61, error: 1'b1, cyc: 8'd17});
        run_decode(1'b0, 32'h61, 0);
        exp_r = sb_q.pop_front();
        n_checks++;
        if (obs !== exp_r) begin
            n_fail++; $display("FAIL ready_late got %s want %s", fmt_res(obs), fmt_res(exp_r));
        end
        delay_u = 0;
    endtask

    task automatic test_signed();
        mem_s[8'h10] = 8'h7F;
        mem_s[8'h20] = 8'hC0; mem_s[8'h21] = 8'hBB; mem_s[8'h22] = 8'h78;
        mem_s[8'h30] = 8'h3F;
        sb_q.push_back('{value: 32'hFFFF_FFFF, next_addr: 32'h11, error: 1'b0, cyc: 8'd3});
        run_decode(1'b1, 32'h10, 0);
        exp_r = sb_q.pop_front();
        n_checks++;
        if (obs !== exp_r) begin
            n_fail++; $display("FAIL signed_m1 got %s want %s", fmt_res(obs), fmt_res(exp_r));
        end
        sb_q.push_back('{value: 32'hFFFE_1DC0, next_addr: 32'h23, error: 1'b0, cyc: 8'd7});
        run_decode(1'b1, 32'h20, 0);
        exp_r = sb_q.pop_front();
        n_checks++;
        if (obs !== exp_r) begin
            n_fail++; $display("FAIL signed_neg got %s want %s", fmt_res(obs), fmt_res(exp_r));
        end
        sb_q.push_back('{value: 32'h0000_003F, next_addr: 32'h31, error: 1'b0, cyc: 8'd3});
        run_decode(1'b1, 32'h30, 0);
        exp_r = sb_q.pop_front();
        n_checks++;
        if (obs !== exp_r) begin
            n_fail++; $display("FAIL signed_pos got %s want %s", fmt_res(obs), fmt_res(exp_r));
        end
    endtask

    task automatic test_start_while_busy();
        bit stray;
        mem_u[8'h70] = 8'hE5; mem_u[8'h71] = 8'h8E; mem_u[8'h72] = 8'h26;
        sb_q.push_back('{value: 32'h0009_8765, next_addr: 32'h73, error: 1'b0, cyc: 8'd7});
        run_decode(1'b0, 32'h70, 3);
        exp_r = sb_q.pop_front();
        n_checks++;
        if (obs !== exp_r) begin
            n_fail++; $display("FAIL busy_start got %s want %s", fmt_res(obs), fmt_res(exp_r));
        end
        stray = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (done_u || busy_u) stray = 1'b1;
        end
        n_checks++;
        if (stray !== 1'b0) begin
            n_fail++; $display("FAIL busy_start_queued got stray_activity=%b want 0", stray);
        end
    endtask

    task automatic test_back_to_back();
        sb_q.push_back('{value: 32'h5, next_addr: 32'h11, error: 1'b0, cyc: 8'd3});
        sb_q.push_back('{value: 32'h0009_8765, next_addr: 32'h23, error: 1'b0, cyc: 8'd7});
        run_decode(1'b0, 32'h10, 0);
        exp_r = sb_q.pop_front();
        n_checks++;
        if (obs !== exp_r) begin
            n_fail++; $display("FAIL b2b_first got %s want %s", fmt_res(obs), fmt_res(exp_r));
        end
        run_decode(1'b0, 32'h20, 0);
        exp_r = sb_q.pop_front();
        n_checks++;
        if (obs !== exp_r) begin
            n_fail++; $display("FAIL b2b_second got %s want %s", fmt_res(obs), fmt_res(exp_r));
        end
    endtask

    task automatic test_reset_midfetch();
        bit reached, stray;
        mem_u[8'h80] = 8'hE5; mem_u[8'h81] = 8'h8E; mem_u[8'h82] = 8'h26;
        @(posedge clk); #1;
        start_u = 1'b1; saddr_u = 32'h80;
        @(posedge clk); #1;
        start_u = 1'b0;
        reached = 1'b0;
        for (int c = 0; c < 10 && !reached; c++) begin
            @(negedge clk);
            if (rom_u.rom_addr == 32'h81 && rom_u.rom_read_en) reached = 1'b1;
        end
        n_checks++;
        if (reached !== 1'b1) begin
            n_fail++; $display("FAIL midfetch_reach got reached=%b want 1", reached);
        end
        rst_n = 1'b0;
        #1;
        n_checks++;
        if ({rom_u.rom_read_en, busy_u, done_u, err_u, val_u, na_u, rom_u.rom_addr} !== 99'd0) begin
            n_fail++;
            $display("FAIL midfetch_reset got rd=%b busy=%b done=%b val=%h next=%h addr=%h want all 0",
                     rom_u.rom_read_en, busy_u, done_u, val_u, na_u, rom_u.rom_addr);
        end
        stray = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            if (done_u) stray = 1'b1;
        end
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (done_u) stray = 1'b1;
        end
        n_checks++;
        if (stray !== 1'b0) begin
            n_fail++; $display("FAIL midfetch_no_done got done_seen=%b want 0", stray);
        end
        sb_q.push_back('{value: 32'h5, next_addr: 32'h11, error: 1'b0, cyc: 8'd3});
        run_decode(1'b0, 32'h10, 0);
        exp_r = sb_q.pop_front();
        n_checks++;
        if (obs !== exp_r) begin
            n_fail++; $display("FAIL after_reset got %s want %s", fmt_res(obs), fmt_res(exp_r));
        end
    endtask

    initial begin
        rst_n   = 1'b0;
        start_u = 1'b0; start_s = 1'b0;
        saddr_u = 32'd0; saddr_s = 32'd0;
        delay_u = 0; delay_s = 0;
        for (int i = 0; i < 256; i++) begin
            mem_u[i] = 8'h00;
            mem_s[i] = 8'h00;
        end
        repeat (2) @(posedge clk);
        test_reset();
        test_timeout();
        test_single_byte();
        test_multi_byte();
        test_max_len();
        test_ready_boundary();
        test_signed();
        test_start_while_busy();
        test_back_to_back();
        test_reset_midfetch();
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/leb128_reader.md
# leb128_reader

Bus-initiating decoder for WebAssembly LEB128 integers: given a start address, it fetches bytes one at a time over the ROM byte-read handshake and returns the decoded 32-bit value together with the address following the encoding. It sits between the wasm loader/parser control logic and the ROM responder, replacing ad-hoc byte loops in the section, index and immediate parsers.

## Interface
- SIGNED, 0: 0 decodes unsigned LEB128 (u32); 1 decodes signed LEB128 (s32, sign-extended).
- MAX_BYTES, 5: maximum encoded length accepted.
- TIMEOUT, 16: cycles `rom_read_en` may stay high without `rom_ready` before the decode aborts.
- clk  in  1  sole clock, all state on posedge.
- rst_n  in  1  asynchronous, active-low reset.
- start  in  1  request pulse; sampled only in IDLE.
- start_addr  in  32  address of the first encoded byte.
- busy  out  1  high from the cycle after `start` is accepted until `done`.
- done  out  1  one-cycle completion pulse.
- error  out  1  valid with `done`; overflow or timeout.
- value  out  32  decoded result, held until the next `start`.
- next_addr  out  32  address after the last accepted byte; held.
- rom_addr  out  32  byte address to the responder.
- rom_read_en  out  1  read request level.
- rom_data  in  8  responder data, valid when `rom_ready` is high.
- rom_ready  in  1  one-cycle response pulse.

## Operation
- States: IDLE, FETCH, DONE.
- IDLE: outputs held. `start`=1 captures `start_addr` into `rom_addr`, clears the accumulator, byte index and timeout counter, then enters FETCH.
- FETCH: `rom_read_en`=1 and `rom_addr` is stable.
- On `rom_ready`:
  - `acc |= (rom_data & 0x7F) << 7*idx`.
  - If bit 7 is set and `idx+1 < MAX_BYTES`: `rom_addr` increments by 1, `idx` increments, timeout counter clears, state stays FETCH.
  - Otherwise: go to DONE.
- The responder ignores a request whose address equals its last served address. The reader never re-requests an address within one decode, and repeated reads of one address across decodes rely on the timeout.
- Final byte checks, applied when `idx` = MAX_BYTES-1 (5th byte at default):
  - Bit 7 set means error.
  - Unsigned: bits 6:4 nonzero means error.
  - Signed: bits 6:4 not all equal to bit 3 means error.
- Signed sign extension: if the last byte's bit 6 = 1 and `7*(idx+1) < 32`, bits `[31:7*(idx+1)]` of the result are set.
- Timeout: counter increments each FETCH cycle without `rom_ready`. Reaching TIMEOUT sets error and goes to DONE; `next_addr` is then the address that timed out.
- DONE (one cycle):
  - `done`=1, `rom_read_en`=0.
  - `value` = result, or 0 on error.
  - `next_addr` = `rom_addr`+1 on success or overflow error.
  - Returns to IDLE.
- `start` while busy or in DONE is ignored, not queued.
- Reset (any time, including mid-FETCH) sets all outputs to 0 immediately and the state to IDLE: `busy`, `done`, `error`, `value`, `next_addr`, `rom_addr`, `rom_read_en`.

## Timing
- The responder registers data: `rom_ready` arrives the cycle after it samples `rom_read_en` with a new address.
- Cost is 2 cycles per byte: a request cycle, then a ready cycle in which the address advances at the closing edge.
- `start` sampled at edge E0 gives `done` in cycle 2N+1 for an N-byte encoding with a zero-wait responder.
- `busy` spans cycles 1..2N and is low in the `done` cycle.
- A `rom_ready` in the same cycle the timeout counter reaches TIMEOUT is accepted (ready wins).
- Back-to-back use: the earliest new `start` is accepted in the cycle after `done`.
- Address arithmetic wraps modulo 2^32.

## Structure
- Shared package `wasm_pkg`: state enum (IDLE/FETCH/DONE), `LEB_U32_MAX_BYTES`=5, `LEB_PAYLOAD_MASK`=8'h7F, `LEB_CONT_BIT`=7.
- Single module, no sub-modules. The timeout counter is `$clog2(TIMEOUT+1)` bits.

## Test plan
- ROM[0x10]=0x05, start_addr 0x10 -> `done` in cycle 3, value 0x5, next_addr 0x11, error 0, `rom_read_en` low in cycle 3.
- ROM[0x20..0x22]=E5 8E 26 -> value 0x00098765 (624485), next_addr 0x23, `done` in cycle 7, `rom_addr` sequence 0x20, 0x21, 0x22.
- FF FF FF FF 0F at 0x30 -> value 0xFFFFFFFF, error 0. FF FF FF FF 1F -> error 1, value 0, next_addr 0x35.
- Fresh responder (last served address 0), start_addr 0x0 -> no `rom_ready`; `done`+error exactly TIMEOUT cycles into FETCH, next_addr 0x0.
- SIGNED=1: 7F -> 0xFFFFFFFF. C0 BB 78 -> 0xFFFE1DC0 (-123456). 3F -> 0x0000003F.
- Assert `rst_n`=0 during the second byte's FETCH -> `rom_read_en` and `busy` are 0 in the same cycle, no `done`. A `start` pulsed while busy -> ignored; the first decode result is unchanged.
